lsu_pipe: RTL
=============

Name: lsu_pipe

Overview:
- Parametrised, multi-cycle load/store unit; successor to the combinational access stage in the NPC memory path.
- Accepts one memory op at a time from the execute stage via valid/ready, computes byte lanes, and issues an aligned request on a simple request/response bus.
- Returns the aligned, sign/zero-extended load result to writeback via valid/ready.
- Adds misalignment detection, illegal-width detection and a bus-timeout error.

Parameters:
- XLEN, 64, data/address width; legal values 32 or 64.
- TIMEOUT, 255, max cycles spent in WAIT before a bus error; 0 disables the timeout.
- CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  op presented.
- in_ready  out  1  unit can accept an op.
- mem_op  in  4  operation code. 0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWU, 7 LD, 8 SB, 9 SH, 10 SW, 11 SD. 12-15 are treated as NONE.
- addr  in  XLEN  effective byte address (execute result).
- wdata  in  XLEN  store data (rs2); the low bytes are used.
- rd_idx  in  5  destination register.
- out_valid  out  1  result available.
- out_ready  in  1  writeback accepts the result.
- out_data  out  XLEN  extended load data; 0 for stores, NONE and exceptions.
- out_rd_idx  out  5  captured rd_idx.
- out_wen  out  1  1 only for a successful load.
- out_exc  out  2  00 ok, 01 misaligned, 10 illegal width, 11 bus timeout.
- bus_req_valid  out  1  request valid.
- bus_req_ready  in  1  bus accepts the request.
- bus_req_addr  out  XLEN  addr with the low log2(XLEN/8) bits cleared.
- bus_req_wen  out  1  1 for stores.
- bus_req_wdata  out  XLEN  store data shifted to its byte lane.
- bus_req_wmask  out  XLEN/8  byte enables; all 0 for loads.
- bus_resp_valid  in  1  response or write acknowledge.
- bus_resp_rdata  in  XLEN  full aligned word.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; timeout counter clears.
  - All outputs are 0 except in_ready.
  - in_ready is combinational: 1 exactly when the state is IDLE, so it reads 1 during reset.
- States: IDLE, REQ, WAIT, DONE.
- Decode:
  - Size is 1, 2, 4 or 8 bytes.
  - Offset is the low bits of addr: addr[2:0] for XLEN=64, addr[1:0] for XLEN=32.
- Misalignment: the op is misaligned when offset mod size != 0.
- IDLE (in_ready=1). On in_valid, capture op, addr, wdata and rd_idx, then take the first matching branch:
  - LD, LWU or SD with XLEN=32: go to DONE, out_exc=10.
  - Misaligned: go to DONE, out_exc=01.
  - NONE: go to DONE, out_exc=00, out_wen=0.
  - Otherwise: go to REQ.
  - No bus traffic is issued on any exception or NONE path.
- REQ:
  - bus_req_valid=1; bus_req_* are held stable until bus_req_ready.
  - wmask = ((1<<size)-1) << offset.
  - wdata is the low size bytes shifted left by offset*8.
  - On the handshake, go to WAIT and clear the counter.
- WAIT:
  - On bus_resp_valid, go to DONE. For loads, shift rdata right by offset*8, then sign- or zero-extend from size bytes and set out_wen=1. For stores, out_data=0 and out_wen=0.
  - Otherwise, increment the counter. When TIMEOUT!=0 and the counter reaches TIMEOUT, go to DONE with out_exc=11, out_wen=0, out_data=0.
- DONE:
  - out_valid=1; out_* are registered and held until out_ready.
  - On out_ready, go to IDLE.
  - in_ready=0 in DONE, so there is no same-cycle re-accept.
- Stray responses: bus_resp_valid outside WAIT is ignored, including a late response after a timeout or after a reset.
- Latency: accept on edge T; REQ during cycle T+1; with immediate ready and response, out_valid rises at T+3. Exception and NONE ops raise out_valid at T+1.
- Reset mid-operation aborts the op with no output. A bus request that is in flight is dropped; the bus must tolerate withdrawal of bus_req_valid.

Test Plan:
- XLEN=64, LB at addr 0x8000_0003, rdata=0x0000_0000_8000_0000 -> bus_req_addr=0x8000_0000, wmask=0, out_data=0xFFFF_FFFF_FFFF_FF80, out_wen=1, out_valid at accept+3.
- SH at addr 0x8000_0006, wdata=0x1234_ABCD -> wmask=0xC0, bus_req_wdata=0xABCD_0000_0000_0000, bus_req_wen=1, out_wen=0, out_exc=00.
- LW at addr 0x8000_0002 -> no bus_req_valid, out_exc=01 at accept+1; LHU at 0x8000_0002 with rdata=0xFFFF_0000 -> out_data=0x0000_FFFF.
- XLEN=32 build, LD at addr 0x0 -> out_exc=10, no bus request; LW at 0x4 with rdata=0x8000_0001 -> out_data=0x8000_0001.
- TIMEOUT=4, no bus_resp_valid -> out_exc=11 after 4 WAIT cycles; a response injected 2 cycles later is ignored and in_ready=1.
- rst pulled low while in WAIT -> all outputs 0 immediately; after release a new LBU at 0x1 with rdata=0xFF00 -> out_data=0xFF.

Source files
------------

// File: rtl/lsu_pipe.sv
// Multi-cycle load/store unit: accepts one op, issues an aligned bus request,
// and returns the extended load result (or an exception code) to writeback.
module lsu_pipe #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        mem_op,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [4:0]        rd_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data,
  output logic [4:0]        out_rd_idx,
  output logic              out_wen,
  output logic [1:0]        out_exc,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [XLEN-1:0]   bus_req_addr,
  output logic              bus_req_wen,
  output logic [XLEN-1:0]   bus_req_wdata,
  output logic [XLEN/8-1:0] bus_req_wmask,
  input  logic              bus_resp_valid,
  input  logic [XLEN-1:0]   bus_resp_rdata
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  // log2 of the access size in bytes
  function automatic logic [1:0] op_lsz(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd8:  return 2'd0;
      4'd3, 4'd4, 4'd9:  return 2'd1;
      4'd5, 4'd6, 4'd10: return 2'd2;
      default:           return 2'd3;
    endcase
  endfunction

  state_t            state;
  logic [3:0]        op_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [CNT_W-1:0]  cnt;

  logic [1:0]        in_lsz;
  logic [OFF_W-1:0]  in_off;
  logic              in_none, in_illegal, in_mis;
  logic [1:0]        q_lsz;
  logic [OFF_W-1:0]  q_off;
  logic              q_store, q_signed;
  logic [NB-1:0]     lane_mask;
  logic [XLEN-1:0]   data_mask, shifted, load_ext;
  logic [IDX_W-1:0]  sb_idx;

  assign in_lsz     = op_lsz(mem_op);
  assign in_off     = addr[OFF_W-1:0];
  assign in_none    = (mem_op == 4'd0) || (mem_op >= 4'd12);
  assign in_illegal = (XLEN == 32) && (mem_op == 4'd6 || mem_op == 4'd7 || mem_op == 4'd11);
  assign in_mis     = (in_off & OFF_W'((4'd1 << in_lsz) - 4'd1)) != '0;

  assign q_lsz    = op_lsz(op_q);
  assign q_off    = addr_q[OFF_W-1:0];
  assign q_store  = op_q >= 4'd8;
  assign q_signed = (op_q == 4'd1) || (op_q == 4'd3) || (op_q == 4'd5);

  always_comb begin
    lane_mask = '1;
    data_mask = '1;
    case (q_lsz)
      2'd0: begin lane_mask = NB'(1);  data_mask = '0; data_mask[7:0]  = '1; end
      2'd1: begin lane_mask = NB'(3);  data_mask = '0; data_mask[15:0] = '1; end
      2'd2: begin lane_mask = NB'(15); data_mask = '0; data_mask[31:0] = '1; end
      default: ;
    endcase
  end

  // Load path: bring the addressed bytes down to bit 0, then extend.
  assign shifted  = bus_resp_rdata >> {q_off, 3'b000};
  assign sb_idx   = IDX_W'((7'd8 << q_lsz) - 7'd1);
  assign load_ext = (shifted & data_mask) |
                    ((q_signed && shifted[sb_idx]) ? ~data_mask : '0);

  assign in_ready      = (state == IDLE);
  assign out_valid     = (state == DONE);
  assign bus_req_valid = (state == REQ);
  assign bus_req_addr  = bus_req_valid ? {addr_q[XLEN-1:OFF_W], OFF_W'(0)} : '0;
  assign bus_req_wen   = bus_req_valid && q_store;
  assign bus_req_wdata = bus_req_wen ? ((wdata_q & data_mask) << {q_off, 3'b000}) : '0;
  assign bus_req_wmask = bus_req_wen ? (lane_mask << q_off) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
      out_data   <= '0;
      out_rd_idx <= '0;
      out_wen    <= 1'b0;
      out_exc    <= 2'b00;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q       <= mem_op;
          addr_q     <= addr;
          wdata_q    <= wdata;
          out_rd_idx <= rd_idx;
          out_data   <= '0;
          out_wen    <= 1'b0;
          out_exc    <= 2'b00;
          cnt        <= '0;
          if (in_illegal) begin
            out_exc <= 2'b10;
            state   <= DONE;
          end else if (in_mis) begin
            out_exc <= 2'b01;
            state   <= DONE;
          end else if (in_none) begin
            state   <= DONE;
          end else begin
            state   <= REQ;
          end
        end
        REQ: if (bus_req_ready) begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: if (bus_resp_valid) begin
          state <= DONE;
          if (!q_store) begin
            out_data <= load_ext;
            out_wen  <= 1'b1;
          end
        end else begin
          cnt <= cnt + 1'b1;
          if (TIMEOUT != 0 && (cnt + 1'b1) == CNT_W'(TIMEOUT)) begin
            out_exc <= 2'b11;
            state   <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
